// File: rtl/memory_clear_sequencer.sv
// Sweeps a block RAM with FILL_VALUE once upstream reset/init allows it, then reports ready.
// Extra passes run on clearRequest; losing rst/isInitialized aborts back to HOLD.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_HOLD  | upstream not ready (or just reset); no writes, not ready
// ST_CLEAR | one write per cycle, address 0..DEPTH-1
// ST_DONE  | memory fully cleared, ready=1, waiting for clearRequest
module memory_clear_sequencer #(
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DEPTH      = 1024,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  rst,
   input  logic                  isInitialized,
   input  logic                  clearRequest,
   output logic                  memWriteEnable,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic [DATA_WIDTH-1:0] memWriteData,
   output logic                  busy,
   output logic                  ready,
   output logic [7:0]            passCount
);

   typedef enum logic [1:0] {ST_HOLD, ST_CLEAR, ST_DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_t                  state_q, state_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    busy_q, busy_d;
   logic                    ready_q, ready_d;
   logic                    pending_q, pending_d;
   logic [7:0]              pass_cnt_q, pass_cnt_d;
   logic                    go;

   assign go = !rst && isInitialized;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= ST_HOLD;
         we_q       <= 1'b0;
         addr_q     <= '0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         pending_q  <= 1'b0;
         pass_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         pending_q  <= pending_d;
         pass_cnt_q <= pass_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      addr_d     = addr_q;
      busy_d     = busy_q;
      ready_d    = ready_q;
      pending_d  = pending_q;
      pass_cnt_d = pass_cnt_q;
      // Abort outranks pass completion and requests; the partial pass is not counted.
      if (!go) begin
         state_d   = ST_HOLD;
         we_d      = 1'b0;
         addr_d    = '0;
         busy_d    = 1'b0;
         ready_d   = 1'b0;
         pending_d = 1'b0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               state_d = ST_CLEAR;
               we_d    = 1'b1;
               addr_d  = '0;
               busy_d  = 1'b1;
               ready_d = 1'b0;
            end
            ST_CLEAR: begin
               if (addr_q == LAST_ADDR) begin
                  if (pass_cnt_q != 8'hFF) pass_cnt_d = pass_cnt_q + 8'd1;
                  addr_d = '0;
                  // A request arriving on the completing edge is dropped: completion wins.
                  if (pending_q) begin
                     pending_d = 1'b0;
                  end else begin
                     state_d = ST_DONE;
                     we_d    = 1'b0;
                     busy_d  = 1'b0;
                     ready_d = 1'b1;
                  end
               end else begin
                  addr_d = addr_q + ADDR_WIDTH'(1);
                  if (clearRequest) pending_d = 1'b1;
               end
            end
            ST_DONE: begin
               if (clearRequest) begin
                  state_d = ST_CLEAR;
                  we_d    = 1'b1;
                  addr_d  = '0;
                  busy_d  = 1'b1;
                  ready_d = 1'b0;
               end
            end
            default: begin
               state_d   = ST_HOLD;
               we_d      = 1'b0;
               addr_d    = '0;
               busy_d    = 1'b0;
               ready_d   = 1'b0;
               pending_d = 1'b0;
            end
         endcase
      end
   end

   assign memWriteEnable = we_q;
   assign memAddr        = addr_q;
   assign memWriteData   = FILL_VALUE;
   assign busy           = busy_q;
   assign ready          = ready_q;
   assign passCount      = pass_cnt_q;

endmodule

// File: tb/tb_memory_clear_sequencer.sv
// Bench for memory_clear_sequencer: directed vector table, hand-written corner sequences,
// and randomized traffic against a pass-level reference model.
module tb_memory_clear_sequencer;

   localparam int              ADDR_WIDTH = 4;
   localparam int              DEPTH      = 16;
   localparam int              DATA_WIDTH = 32;
   localparam logic [31:0]     FILL       = 32'hA5A5_0F0F;

   logic                  clk = 1'b0;
   logic                  resetn = 1'b0;
   logic                  rst = 1'b1;
   logic                  isInitialized = 1'b0;
   logic                  clearRequest = 1'b0;
   logic                  memWriteEnable;
   logic [ADDR_WIDTH-1:0] memAddr;
   logic [DATA_WIDTH-1:0] memWriteData;
   logic                  busy;
   logic                  ready;
   logic [7:0]            passCount;

   always #5 clk = ~clk;

   memory_clear_sequencer #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH(DEPTH),
      .DATA_WIDTH(DATA_WIDTH),
      .FILL_VALUE(FILL)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .rst(rst),
      .isInitialized(isInitialized),
      .clearRequest(clearRequest),
      .memWriteEnable(memWriteEnable),
      .memAddr(memAddr),
      .memWriteData(memWriteData),
      .busy(busy),
      .ready(ready),
      .passCount(passCount)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a pass in progress is "writing word idx"; completed passes are counted.
   bit m_writing, m_ready, m_extra;
   int m_idx, m_passes;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic rn, input logic r, input logic i, input logic q);
      if (!rn) begin
         m_writing = 0; m_ready = 0; m_extra = 0; m_idx = 0; m_passes = 0;
      end else if (r || !i) begin
         m_writing = 0; m_ready = 0; m_extra = 0; m_idx = 0;
      end else if (m_writing) begin
         if (m_idx == DEPTH - 1) begin
            m_passes = (m_passes < 255) ? m_passes + 1 : 255;
            m_idx = 0;
            if (m_extra) m_extra = 0;
            else begin m_writing = 0; m_ready = 1; end
         end else begin
            m_idx++;
            if (q) m_extra = 1;
         end
      end else if (m_ready) begin
         if (q) begin m_ready = 0; m_writing = 1; m_idx = 0; end
      end else begin
         m_writing = 1; m_idx = 0;
      end
   endtask

   task automatic check_model();
      chk("model_we", memWriteEnable, m_writing);
      chk("model_addr", memAddr, m_idx);
      chk("model_busy", busy, m_writing);
      chk("model_ready", ready, m_ready);
      chk("model_passes", passCount, m_passes);
      chk("fill_data", memWriteData, FILL);
      chk("addr_in_range", memAddr <= ADDR_WIDTH'(DEPTH - 1), 1);
      chk("no_we_when_ready", memWriteEnable && ready, 0);
   endtask

   task automatic step(input logic rn, input logic r, input logic i, input logic q);
      @(negedge clk);
      resetn = rn; rst = r; isInitialized = i; clearRequest = q;
      @(posedge clk);
      model_edge(rn, r, i, q);
      #1;
      check_model();
   endtask

   typedef struct {
      logic resetn, rst, init, req;
      int   n;
      logic we;
      int   addr;
      logic rdy, bsy;
      int   cnt;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int wr, guard;
      // {resetn, rst, init, req, cycles, we, addr, ready, busy, passCount} after the last cycle
      vecs[0] = '{0, 1, 0, 0, 3,  0, 0,  0, 0, 0};
      vecs[1] = '{1, 1, 0, 0, 40, 0, 0,  0, 0, 0};
      vecs[2] = '{1, 0, 0, 0, 2,  0, 0,  0, 0, 0};
      vecs[3] = '{1, 0, 1, 0, 1,  1, 0,  0, 1, 0};
      vecs[4] = '{1, 0, 1, 0, 15, 1, 15, 0, 1, 0};
      vecs[5] = '{1, 0, 1, 0, 1,  0, 0,  1, 0, 1};
      vecs[6] = '{1, 0, 1, 0, 5,  0, 0,  1, 0, 1};
      vecs[7] = '{1, 0, 1, 1, 1,  1, 0,  0, 1, 1};
      vecs[8] = '{1, 0, 1, 0, 16, 0, 0,  1, 0, 2};

      for (int v = 0; v < 9; v++) begin
         repeat (vecs[v].n) step(vecs[v].resetn, vecs[v].rst, vecs[v].init, vecs[v].req);
         chk($sformatf("vec%0d_we", v), memWriteEnable, vecs[v].we);
         chk($sformatf("vec%0d_addr", v), memAddr, vecs[v].addr);
         chk($sformatf("vec%0d_ready", v), ready, vecs[v].rdy);
         chk($sformatf("vec%0d_busy", v), busy, vecs[v].bsy);
         chk($sformatf("vec%0d_passes", v), passCount, vecs[v].cnt);
      end

      // Two requests mid-pass collapse into one extra back-to-back pass.
      step(1, 0, 1, 1);
      wr = memWriteEnable ? 1 : 0;
      guard = 0;
      while (memWriteEnable && guard < 100) begin
         step(1, 0, 1, (wr == 6 || wr == 10));
         if (memWriteEnable) wr++;
         guard++;
      end
      chk("burst_timeout", guard < 100, 1);
      chk("burst_len", wr, 32);
      chk("burst_passes", passCount, 4);
      chk("burst_ready", ready, 1);

      // rst raised at address 7 aborts; partial pass not counted; full pass restarts.
      step(1, 0, 1, 1);
      wr = 1;
      while (wr < 8) begin step(1, 0, 1, 0); wr++; end
      chk("abort_pre_addr", memAddr, 7);
      step(1, 1, 1, 0);
      chk("abort_we", memWriteEnable, 0);
      chk("abort_passes", passCount, 4);
      step(1, 1, 1, 0);
      step(1, 1, 1, 0);
      step(1, 0, 1, 0);
      chk("restart_we", memWriteEnable, 1);
      chk("restart_addr", memAddr, 0);
      repeat (15) step(1, 0, 1, 0);
      chk("restart_last_addr", memAddr, 15);
      step(1, 0, 1, 0);
      chk("restart_ready", ready, 1);
      chk("restart_passes", passCount, 5);

      // passCount saturates.
      repeat (260) begin
         step(1, 0, 1, 1);
         repeat (16) step(1, 0, 1, 0);
      end
      chk("sat_passes", passCount, 255);
      chk("sat_ready", ready, 1);

      // resetn mid-pass returns everything to reset values.
      step(1, 0, 1, 1);
      repeat (4) step(1, 0, 1, 0);
      step(0, 0, 1, 0);
      chk("rstn_we", memWriteEnable, 0);
      chk("rstn_addr", memAddr, 0);
      chk("rstn_busy", busy, 0);
      chk("rstn_ready", ready, 0);
      chk("rstn_passes", passCount, 0);
      step(1, 0, 1, 0);
      chk("post_rstn_we", memWriteEnable, 1);
      chk("post_rstn_addr", memAddr, 0);

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(0, 499) != 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 39) != 0, $urandom_range(0, 7) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
